// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes, ALUOp codes and the issue FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } issue_state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct decode into the 3-bit ALUControl code plus an illegal flag.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] code_o,
    output logic       illegal_o
);

    always_comb begin
        code_o    = ALU_ADD;
        illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_ADD: code_o = ALU_ADD;
            ALUOP_SUB: code_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type with funct7[5] set subtracts; addi never does.
                    F3_ADDSUB: code_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    F3_SLT:    code_o = ALU_SLT;
                    F3_OR:     code_o = ALU_OR;
                    F3_AND:    code_o = ALU_AND;
                    default:   illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: request handshake -> registered ALU operands -> captured response.
// Optional macro ALU_ISSUE_ILLEGAL_EN flags illegal decodes via rsp_err and masks the result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [2:0]       req_funct3,
    input  logic             req_op5,
    input  logic             req_funct7b5,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             Zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    issue_state_t     state_q, state_d;
    logic [WIDTH-1:0] srca_q, srca_d;
    logic [WIDTH-1:0] srcb_q, srcb_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic             ill_q, ill_d;
    logic             err_q, err_d;
`endif

    logic [2:0] dec_code;
    logic       dec_illegal;
    logic [2:0] issue_code;

    alu_decoder u_dec (
        .aluop_i    (req_aluop),
        .funct3_i   (req_funct3),
        .op5_i      (req_op5),
        .funct7b5_i (req_funct7b5),
        .code_o     (dec_code),
        .illegal_o  (dec_illegal)
    );

    // Illegal decodes always issue as add; only the response side differs by build.
    assign issue_code = dec_illegal ? ALU_ADD : dec_code;

    always_comb begin
        state_d     = state_q;
        srca_d      = srca_q;
        srcb_d      = srcb_q;
        ctrl_d      = ctrl_q;
        rsp_valid_d = rsp_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
        ill_d       = ill_q;
        err_d       = err_q;
`endif
        req_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    srca_d  = req_a;
                    srcb_d  = req_b;
                    ctrl_d  = issue_code;
`ifdef ALU_ISSUE_ILLEGAL_EN
                    ill_d   = dec_illegal;
`endif
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d    = ALUResult;
                zero_d      = Zero;
`ifdef ALU_ISSUE_ILLEGAL_EN
                if (ill_q) begin
                    result_d = '0;
                    zero_d   = 1'b0;
                end
                err_d       = ill_q;
`endif
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
                    err_d       = 1'b0;
`endif
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            srca_q      <= '0;
            srcb_q      <= '0;
            ctrl_q      <= ALU_ADD;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            ill_q       <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            srca_q      <= srca_d;
            srcb_q      <= srcb_d;
            ctrl_q      <= ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
            ill_q       <= ill_d;
            err_q       <= err_d;
`endif
        end
    end

    assign SrcA       = srca_q;
    assign SrcB       = srcb_q;
    assign ALUControl = ctrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit ALU closing the loop.
module tb_alu_issue_ctrl;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_aluop;
    logic [2:0]   req_funct3;
    logic         req_op5;
    logic         req_funct7b5;
    logic [W-1:0] req_a, req_b;
    logic [W-1:0] SrcA, SrcB;
    logic [2:0]   ALUControl;
    logic [W-1:0] ALUResult;
    logic         Zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_aluop    (req_aluop),
        .req_funct3   (req_funct3),
        .req_op5      (req_op5),
        .req_funct7b5 (req_funct7b5),
        .req_a        (req_a),
        .req_b        (req_b),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .ALUControl   (ALUControl),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_err      (rsp_err)
    );

    // Reference ALU
    always_comb begin
        case (ALUControl)
            3'b000:  ALUResult = SrcA + SrcB;
            3'b001:  ALUResult = SrcA - SrcB;
            3'b010:  ALUResult = SrcA & SrcB;
            3'b011:  ALUResult = SrcA | SrcB;
            3'b101:  ALUResult = ($signed(SrcA) < $signed(SrcB)) ? 4'd1 : 4'd0;
            default: ALUResult = '0;
        endcase
        Zero = (ALUResult == '0);
    end

    typedef struct {
        logic [1:0]   aluop;
        logic [2:0]   f3;
        logic         op5;
        logic         f7;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   ctrl;
        logic [W-1:0] res;
        logic         z;
        logic         err;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [2:0] f3, input logic o5,
                             input logic f7, input logic [W-1:0] a, input logic [W-1:0] b);
        req_aluop    = op;
        req_funct3   = f3;
        req_op5      = o5;
        req_funct7b5 = f7;
        req_a        = a;
        req_b        = b;
        req_valid    = 1'b1;
    endtask

    // Starts #1 after a posedge with the DUT idle.
    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        drive_req(v.aluop, v.f3, v.op5, v.f7, v.a, v.b);
        chk($sformatf("v%0d_req_ready", i), {7'd0, req_ready}, 8'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk($sformatf("v%0d_ctrl", i), {5'd0, ALUControl}, {5'd0, v.ctrl});
        chk($sformatf("v%0d_srca", i), {4'd0, SrcA}, {4'd0, v.a});
        chk($sformatf("v%0d_srcb", i), {4'd0, SrcB}, {4'd0, v.b});
        chk($sformatf("v%0d_exec_valid", i), {7'd0, rsp_valid}, 8'd0);
        chk($sformatf("v%0d_exec_ready", i), {7'd0, req_ready}, 8'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_rsp_valid", i), {7'd0, rsp_valid}, 8'd1);
        chk($sformatf("v%0d_result", i), {4'd0, rsp_result}, {4'd0, v.res});
        chk($sformatf("v%0d_zero", i), {7'd0, rsp_zero}, {7'd0, v.z});
        chk($sformatf("v%0d_err", i), {7'd0, rsp_err}, {7'd0, v.err});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_done_valid", i), {7'd0, rsp_valid}, 8'd0);
        chk($sformatf("v%0d_done_err", i), {7'd0, rsp_err}, 8'd0);
        chk($sformatf("v%0d_done_ready", i), {7'd0, req_ready}, 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 3'b000, 1'b0, 1'b0, 4'h3, 4'h4, 3'b000, 4'h7, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 3'b000, 1'b1, 1'b1, 4'h5, 4'h5, 3'b001, 4'h0, 1'b1, 1'b0};
        vecs[2] = '{2'b01, 3'b111, 1'b0, 1'b0, 4'h9, 4'h2, 3'b001, 4'h7, 1'b0, 1'b0};
        vecs[3] = '{2'b10, 3'b000, 1'b0, 1'b1, 4'h6, 4'hA, 3'b000, 4'h0, 1'b1, 1'b0};
        vecs[4] = '{2'b10, 3'b000, 1'b1, 1'b0, 4'h2, 4'h3, 3'b000, 4'h5, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 3'b010, 1'b1, 1'b0, 4'hE, 4'h1, 3'b101, 4'h1, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 3'b010, 1'b1, 1'b0, 4'h3, 4'h3, 3'b101, 4'h0, 1'b1, 1'b0};
        vecs[7] = '{2'b10, 3'b110, 1'b1, 1'b0, 4'h5, 4'hA, 3'b011, 4'hF, 1'b0, 1'b0};
        vecs[8] = '{2'b10, 3'b111, 1'b1, 1'b0, 4'hC, 4'hA, 3'b010, 4'h8, 1'b0, 1'b0};
`ifdef ALU_ISSUE_ILLEGAL_EN
        vecs[9]  = '{2'b11, 3'b000, 1'b0, 1'b0, 4'h2, 4'h3, 3'b000, 4'h0, 1'b0, 1'b1};
        vecs[10] = '{2'b10, 3'b001, 1'b0, 1'b0, 4'hF, 4'h1, 3'b000, 4'h0, 1'b0, 1'b1};
`else
        vecs[9]  = '{2'b11, 3'b000, 1'b0, 1'b0, 4'h2, 4'h3, 3'b000, 4'h5, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 3'b001, 1'b0, 1'b0, 4'hF, 4'h1, 3'b000, 4'h0, 1'b1, 1'b0};
`endif

        reset        = 1'b1;
        rsp_ready    = 1'b0;
        req_valid    = 1'b0;
        req_aluop    = 2'b00;
        req_funct3   = 3'b000;
        req_op5      = 1'b0;
        req_funct7b5 = 1'b0;
        req_a        = '0;
        req_b        = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rst_srca", {4'd0, SrcA}, 8'd0);
        chk("rst_srcb", {4'd0, SrcB}, 8'd0);
        chk("rst_ctrl", {5'd0, ALUControl}, 8'd0);
        chk("rst_result", {4'd0, rsp_result}, 8'd0);
        chk("rst_zero", {7'd0, rsp_zero}, 8'd0);
        chk("rst_err", {7'd0, rsp_err}, 8'd0);
        reset = 1'b0;
        chk("rst_req_ready", {7'd0, req_ready}, 8'd1);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Backpressure: response held for 5 cycles while a different request waits
        drive_req(2'b00, 3'b000, 1'b0, 1'b0, 4'h1, 4'h2);
        @(posedge clk); #1;
        drive_req(2'b01, 3'b000, 1'b0, 1'b0, 4'h9, 4'h9);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_valid", c), {7'd0, rsp_valid}, 8'd1);
            chk($sformatf("bp%0d_result", c), {4'd0, rsp_result}, 8'h3);
            chk($sformatf("bp%0d_zero", c), {7'd0, rsp_zero}, 8'd0);
            chk($sformatf("bp%0d_req_ready", c), {7'd0, req_ready}, 8'd0);
            chk($sformatf("bp%0d_srca", c), {4'd0, SrcA}, 8'h1);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        chk("bp_rel_valid", {7'd0, rsp_valid}, 8'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_hs_valid", {7'd0, rsp_valid}, 8'd0);
        chk("bp_hs_ready", {7'd0, req_ready}, 8'd1);
        chk("bp_hs_srca", {4'd0, SrcA}, 8'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_next_srca", {4'd0, SrcA}, 8'h9);
        chk("bp_next_ctrl", {5'd0, ALUControl}, 8'h1);
        @(posedge clk); #1;
        chk("bp_next_valid", {7'd0, rsp_valid}, 8'd1);
        chk("bp_next_result", {4'd0, rsp_result}, 8'h0);
        chk("bp_next_zero", {7'd0, rsp_zero}, 8'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: request always valid, response always accepted
        drive_req(2'b00, 3'b000, 1'b0, 1'b0, 4'h0, 4'h1);
        begin
            int acc;
            logic took;
            acc = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                chk($sformatf("b2b%0d_ready", c), {7'd0, req_ready}, (c % 3 == 0) ? 8'd1 : 8'd0);
                chk($sformatf("b2b%0d_rvalid", c), {7'd0, rsp_valid}, (c % 3 == 2) ? 8'd1 : 8'd0);
                if (rsp_valid)
                    chk($sformatf("b2b%0d_result", c), {4'd0, rsp_result}, 8'((c / 3) + 1));
                took = req_ready;
                @(posedge clk); #1;
                if (took) begin
                    acc++;
                    req_a = 4'(acc);
                end
            end
            chk("b2b_accepts", 8'(acc), 8'd4);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;

        // Reset while in EXEC discards the op
        drive_req(2'b01, 3'b000, 1'b0, 1'b0, 4'h3, 4'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mr_srca_pre", {4'd0, SrcA}, 8'h3);
        chk("mr_ctrl_pre", {5'd0, ALUControl}, 8'h1);
        #2 reset = 1'b1;
        #1;
        chk("mr_valid", {7'd0, rsp_valid}, 8'd0);
        chk("mr_ctrl", {5'd0, ALUControl}, 8'd0);
        chk("mr_srca", {4'd0, SrcA}, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mr_req_ready", {7'd0, req_ready}, 8'd1);
        @(posedge clk); #1;
        chk("mr_no_ghost", {7'd0, rsp_valid}, 8'd0);
        chk("mr_still_idle", {7'd0, req_ready}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
